// File: rtl/qfifo_dispatch_ctrl.sv
// Read-side scheduler: pops operand FIFO, issues to quaternion multiplier, hands off result.
// Optional stall counter enabled by defining QDISP_PERF_CNT_EN.
module qfifo_dispatch_ctrl #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 32,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            fifo_empty,
  output logic            fifo_read_en,
  output logic            mult_start,
  input  logic            mult_done,
  input  logic [4*DW-1:0] mult_result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4*DW-1:0] res_q,
  output logic            busy,
  output logic            timeout_err,
  input  logic            err_clr,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] wait_cnt;

  logic can_pop;
  logic xfer;
  logic tmo;

  assign can_pop = enable && !fifo_empty;
  assign xfer    = (state == S_OUT) && res_ready;
  assign tmo     = (state == S_WAIT) && !mult_done
                && (wait_cnt == LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (can_pop) state_nx = S_POP;
      S_POP:   state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // completion beats the timeout on the final cycle
        if (mult_done) state_nx = S_OUT;
        else if (tmo)  state_nx = S_IDLE;
      end
      S_OUT: begin
        if (res_ready)
          state_nx = can_pop ? S_POP : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      res_q       <= '0;
      timeout_err <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt + TW'(1);
      if ((state == S_WAIT) && mult_done)
        res_q <= mult_result;
      if (tmo)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
      if (xfer)
        op_count <= op_count + CNT_W'(1);
    end
  end

  assign fifo_read_en = (state == S_POP);
  assign mult_start   = (state == S_ISSUE);
  assign res_valid    = (state == S_OUT);
  assign busy         = (state != S_IDLE);

`ifdef QDISP_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic             stall_hit;

  assign stall_hit = ((state == S_OUT) && !res_ready)
                  || ((state == S_IDLE) && enable && fifo_empty);

  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (stall_hit && !(&stall_q))
      stall_q <= stall_q + CNT_W'(1);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_qfifo_dispatch_ctrl.sv
// Bench for qfifo_dispatch_ctrl: FIFO/multiplier models plus result scoreboard.
// Stall counter expectations follow QDISP_PERF_CNT_EN.
module tb_qfifo_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_read_en;
  logic        mult_start;
  logic        mult_done;
  logic [63:0] mult_result;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_q;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;
  logic [15:0] op_count;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fifo_cnt = 0;
  int lat = 3;
  int cd = 0;
  int stall_left = 0;
  bit hang = 0;
  bit stray = 0;
  bit prev_rd = 0;
  logic [15:0] exp_ops = 0;
  logic [63:0] exp_q[$];
  int pop_cyc[$];
  int start_cyc[$];

  qfifo_dispatch_ctrl #(.DW(16), .TIMEOUT(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
    .mult_start(mult_start), .mult_done(mult_done),
    .mult_result(mult_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_q(res_q), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr),
    .op_count(op_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic load(input int n);
    fifo_cnt   = fifo_cnt + n;
    fifo_empty = (fifo_cnt == 0);
  endtask

  // one clock: observe outputs #1 after the edge, update models, drive inputs
  task automatic step();
    logic [63:0] e;
    @(posedge clk);
    #1;
    cyc++;
    mult_done = 1'b0;
    if (fifo_read_en) begin
      checks++;
      if (fifo_cnt == 0 || prev_rd) begin
        errors++;
        $display("FAIL pop_guard cyc=%0d fifo_cnt=%0d prev_pop=%0b", cyc, fifo_cnt, prev_rd);
      end else begin
        fifo_cnt--;
      end
      pop_cyc.push_back(cyc);
    end
    prev_rd    = fifo_read_en;
    fifo_empty = (fifo_cnt == 0);
    if (mult_start) begin
      start_cyc.push_back(cyc);
      cd = hang ? 0 : lat;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        mult_done   = 1'b1;
        mult_result = {$urandom, $urandom};
        exp_q.push_back(mult_result);
      end
    end
    if (stray) mult_done = 1'b1;
    res_ready = !(res_valid && stall_left > 0);
    if (res_valid && stall_left > 0) stall_left--;
    if (res_valid && res_ready) begin
      checks++;
      exp_ops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d res_q=%h", cyc, res_q);
      end else begin
        e = exp_q.pop_front();
        if (res_q !== e) begin
          errors++;
          $display("FAIL scoreboard cyc=%0d got %h want %h", cyc, res_q, e);
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cd = 0;
    exp_q.delete();
    fifo_cnt = 0;
    fifo_empty = 1'b1;
    stall_left = 0;
    prev_rd = 0;
    exp_ops = 0;
    stray = 0;
    hang = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({fifo_read_en, mult_start, res_valid, busy, timeout_err} !== 5'b0 ||
        op_count !== 16'd0 || stall_cnt !== 16'd0 || res_q !== 64'd0) begin
      errors++;
      $display("FAIL %s got rd=%0b st=%0b rv=%0b busy=%0b te=%0b ops=%0d stall=%0d res_q=%h want all 0",
               nm, fifo_read_en, mult_start, res_valid, busy, timeout_err, op_count, stall_cnt, res_q);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    fifo_empty = 1'b1;
    mult_done = 1'b0;
    mult_result = '0;
    res_ready = 1'b0;
    err_clr = 1'b0;
    step();
    step();
    check_zero("reset_held");
    reset = 1'b0;
    step();
    check_zero("reset_release");
  endtask

  task automatic test_single();
    int t = -1;
    int rv = -1;
    bit seen6 = 0;
    pop_cyc.delete();
    start_cyc.delete();
    lat = 3;
    enable = 1'b1;
    load(1);
    for (int i = 0; i < 15; i++) begin
      step();
      if (t < 0 && pop_cyc.size() > 0) t = pop_cyc[0];
      if (res_valid && rv < 0) rv = cyc;
      if (t >= 0 && cyc == t + 6) begin
        seen6 = 1;
        checks++;
        if (busy !== 1'b0 || op_count !== 16'd1) begin
          errors++;
          $display("FAIL single_done got busy=%0b ops=%0d want busy=0 ops=1", busy, op_count);
        end
      end
    end
    checks++;
    if (start_cyc.size() != 1 || t < 0 || start_cyc[0] != t + 1) begin
      errors++;
      $display("FAIL single_start got starts=%0d pop=%0d want one start at pop+1", start_cyc.size(), t);
    end
    checks++;
    if (t < 0 || rv != t + 5) begin
      errors++;
      $display("FAIL single_valid got %0d want %0d", rv, t + 5);
    end
    checks++;
    if (!seen6) begin
      errors++;
      $display("FAIL single_t6 got no pop want pop+6 checkpoint");
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] base;
    logic [63:0] rq0;
    int nrv = 0;
    bit done1 = 0;
    base = stall_cnt;
    pop_cyc.delete();
    stall_left = 5;
    enable = 1'b1;
    load(2);
    for (int i = 0; i < 30; i++) begin
      step();
      if (res_valid && !done1) begin
        if (nrv == 0) rq0 = res_q;
        nrv++;
        checks++;
        if (res_q !== rq0) begin
          errors++;
          $display("FAIL bp_stable got %h want %h", res_q, rq0);
        end
        if (res_ready) begin
          done1 = 1;
          checks++;
          if (nrv != 6 || pop_cyc.size() != 1) begin
            errors++;
            $display("FAIL bp_hold got valid_cycles=%0d pops=%0d want 6 and 1", nrv, pop_cyc.size());
          end
          checks++;
`ifdef QDISP_PERF_CNT_EN
          if (stall_cnt !== base + 16'd5) begin
            errors++;
            $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, base + 16'd5);
          end
`else
          if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_stall_cnt got %0d want 0", stall_cnt);
          end
`endif
        end
      end
    end
    checks++;
    if (!done1 || op_count !== exp_ops || pop_cyc.size() != 2) begin
      errors++;
      $display("FAIL bp_end got done=%0b ops=%0d pops=%0d want done ops=%0d pops=2",
               done1, op_count, pop_cyc.size(), exp_ops);
    end
  endtask

  task automatic test_stream();
    logic [15:0] b;
    b = exp_ops;
    pop_cyc.delete();
    lat = 3;
    enable = 1'b1;
    load(3);
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (pop_cyc.size() != 3) begin
      errors++;
      $display("FAIL stream_pops got %0d want 3", pop_cyc.size());
    end else begin
      checks++;
      if (pop_cyc[1] - pop_cyc[0] != 6 || pop_cyc[2] - pop_cyc[1] != 6) begin
        errors++;
        $display("FAIL stream_gap got %0d,%0d want 6,6",
                 pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
      end
    end
    checks++;
    if (op_count !== b + 16'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_ops got %0d want %0d", op_count, b + 16'd3);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] b;
    int te = -1;
    bit te_busy = 1;
    int nrv = 0;
    b = exp_ops;
    start_cyc.delete();
    hang = 1;
    enable = 1'b1;
    load(1);
    for (int i = 0; i < 50; i++) begin
      step();
      if (res_valid) nrv++;
      if (timeout_err && te < 0) begin
        te = cyc;
        te_busy = busy;
      end
    end
    checks++;
    if (start_cyc.size() != 1 || te != start_cyc[0] + 33 || te_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_when got %0d busy=%0b want start+33 busy=0", te, te_busy);
    end
    checks++;
    if (op_count !== b || nrv != 0) begin
      errors++;
      $display("FAIL timeout_ops got ops=%0d valid=%0d want ops=%0d valid=0", op_count, nrv, b);
    end
    hang = 0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got %0b want 0", timeout_err);
    end
    lat = 3;
    load(1);
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (op_count !== b + 16'd1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout got ops=%0d te=%0b want ops=%0d te=0", op_count, timeout_err, b + 16'd1);
    end
  endtask

  task automatic test_done_wins();
    logic [15:0] b;
    b = exp_ops;
    lat = 32;
    load(1);
    for (int i = 0; i < 45; i++) step();
    checks++;
    if (timeout_err !== 1'b0 || op_count !== b + 16'd1) begin
      errors++;
      $display("FAIL done_wins got te=%0b ops=%0d want te=0 ops=%0d", timeout_err, op_count, b + 16'd1);
    end
    lat = 3;
  endtask

  task automatic test_enable_drop();
    logic [15:0] b;
    int k = -1;
    b = exp_ops;
    pop_cyc.delete();
    start_cyc.delete();
    enable = 1'b1;
    load(2);
    for (int i = 0; i < 20; i++) begin
      step();
      if (k < 0 && start_cyc.size() > 0) k = i;
      if (k >= 0 && i == k + 1) enable = 1'b0;
    end
    checks++;
    if (pop_cyc.size() != 1 || op_count !== b + 16'd1) begin
      errors++;
      $display("FAIL en_drop got pops=%0d ops=%0d want 1 and %0d", pop_cyc.size(), op_count, b + 16'd1);
    end
    enable = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (pop_cyc.size() != 2 || op_count !== b + 16'd2 || fifo_cnt != 0) begin
      errors++;
      $display("FAIL en_resume got pops=%0d ops=%0d want 2 and %0d", pop_cyc.size(), op_count, b + 16'd2);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    start_cyc.delete();
    hang = 1;
    enable = 1'b1;
    load(1);
    for (int i = 0; i < 10 && start_cyc.size() == 0; i++) step();
    step();
    step();
    do_reset();
    check_zero("reset_wait");
    enable = 1'b0;
    stray = 1;
    step();
    stray = 0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_q !== 64'd0) begin
      errors++;
      $display("FAIL stray_done got busy=%0b rv=%0b res_q=%h want 0", busy, res_valid, res_q);
    end
    enable = 1'b1;
    lat = 3;
    stall_left = 100;
    load(1);
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = res_valid;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_out_reach got no res_valid want res_valid");
    end
    enable = 1'b0;
    do_reset();
    check_zero("reset_out");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_timeout();
    test_done_wins();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
